pixel_stream_tx: RTL and testbench

PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

---
 rtl/vga_stream_pkg.sv | 31 +++
 rtl/pixel_stream_tx_if.sv | 12 +
 rtl/frame_cursor.sv | 54 +++++
 rtl/pixel_stream_tx.sv | 119 +++++++++++
 tb/tb_pixel_stream_tx.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/vga_stream_pkg.sv
// Shared definitions for the VGA pixel streaming blocks: FSM states,
// cursor width and the H/V timing sets selected at build time.
package vga_stream_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_e;

  localparam int unsigned CURSOR_W = 11;

`ifdef VGA_800X600
  localparam int unsigned VGA_H_LIMIT  = 1056;
  localparam int unsigned VGA_V_LIMIT  = 628;
  localparam int unsigned VGA_H_ACTIVE = 800;
  localparam int unsigned VGA_V_ACTIVE = 600;
`else
  localparam int unsigned VGA_H_LIMIT  = 800;
  localparam int unsigned VGA_V_LIMIT  = 525;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_V_ACTIVE = 480;
`endif

  function automatic logic is_active(input logic [CURSOR_W-1:0] h,
                                     input logic [CURSOR_W-1:0] v,
                                     input logic [CURSOR_W-1:0] h_act,
                                     input logic [CURSOR_W-1:0] v_act);
    return (h < h_act) && (v < v_act);
  endfunction

endpackage

// File: rtl/pixel_stream_tx_if.sv
// Upstream pixel handshake: the source offers valid/data, the transmitter
// answers with a combinational consume strobe.
interface pixel_stream_tx_if #(
  parameter int unsigned DATA_SIZE = 15
);
  logic                 i_pix_valid;
  logic [DATA_SIZE-1:0] i_pix_data;
  logic                 o_pix_req;

  modport master (output i_pix_valid, output i_pix_data, input o_pix_req);
  modport slave  (input i_pix_valid, input i_pix_data, output o_pix_req);
endinterface

// File: rtl/frame_cursor.sv
// Raster position counter: H steps every enabled cycle, V steps on H wrap,
// both wrap at their limits; clear forces the origin.
module frame_cursor
  import vga_stream_pkg::*;
#(
  parameter int unsigned H_LIMIT = VGA_H_LIMIT,
  parameter int unsigned V_LIMIT = VGA_V_LIMIT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                en,
  input  logic                clr,
  output logic [CURSOR_W-1:0] h,
  output logic [CURSOR_W-1:0] v,
  output logic                last
);

  localparam logic [CURSOR_W-1:0] H_MAX = CURSOR_W'(H_LIMIT - 1);
  localparam logic [CURSOR_W-1:0] V_MAX = CURSOR_W'(V_LIMIT - 1);

  logic [CURSOR_W-1:0] h_q, h_d;
  logic [CURSOR_W-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (clr) begin
      h_d = '0;
      v_d = '0;
    end else if (en) begin
      if (h_q == H_MAX) begin
        h_d = '0;
        v_d = (v_q == V_MAX) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h    = h_q;
  assign v    = v_q;
  assign last = (h_q == H_MAX) && (v_q == V_MAX);

endmodule

// File: rtl/pixel_stream_tx.sv
// Gap-free raster transmitter: pulls pixels during the active window,
// fills blanking with zeros and emits a registered, cursor-tagged stream.
module pixel_stream_tx
  import vga_stream_pkg::*;
#(
  parameter int unsigned H_LIMIT   = VGA_H_LIMIT,
  parameter int unsigned V_LIMIT   = VGA_V_LIMIT,
  parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
  parameter int unsigned DATA_SIZE = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_stop,
  pixel_stream_tx_if.slave     pix,
  output logic                 o_is_new_read,
  output logic [DATA_SIZE-1:0] o_data,
  output logic [CURSOR_W-1:0]  o_h_cursor,
  output logic [CURSOR_W-1:0]  o_v_cursor,
  output logic                 o_frame_done,
  output logic                 o_underflow
);

  state_e                state_q, state_d;
  logic                  stop_req_q, stop_req_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_SIZE-1:0]  data_q, data_d;
  logic [CURSOR_W-1:0]   h_q, h_d, v_q, v_d;
  logic                  new_q, new_d, done_q, done_d;
  logic                  cur_en, cur_clr, cur_last, pix_req;
  logic [CURSOR_W-1:0]   cur_h, cur_v;

  frame_cursor #(.H_LIMIT(H_LIMIT), .V_LIMIT(V_LIMIT)) u_cursor (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .en     (cur_en),
    .clr    (cur_clr),
    .h      (cur_h),
    .v      (cur_v),
    .last   (cur_last)
  );

  always_comb begin
    state_d     = state_q;
    stop_req_d  = stop_req_q;
    underflow_d = underflow_q;
    cur_en      = 1'b0;
    cur_clr     = 1'b0;
    pix_req     = 1'b0;
    data_d      = '0;
    h_d         = '0;
    v_d         = '0;
    new_d       = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cur_clr    = 1'b1;
        stop_req_d = 1'b0;
        if (i_start) begin
          state_d     = S_STREAM;
          underflow_d = 1'b0;
          // A stop seen together with start still grants one full frame.
          stop_req_d  = i_stop;
        end
      end
      S_STREAM: begin
        cur_en = 1'b1;
        h_d    = cur_h;
        v_d    = cur_v;
        new_d  = (cur_h == '0) && (cur_v == '0);
        done_d = cur_last;
        if (i_stop) stop_req_d = 1'b1;
        if (is_active(cur_h, cur_v, CURSOR_W'(H_ACTIVE), CURSOR_W'(V_ACTIVE))) begin
          pix_req = pix.i_pix_valid;
          if (pix.i_pix_valid) data_d = pix.i_pix_data;
          else                 underflow_d = 1'b1;
        end
        // Stop is honoured only at the frame boundary, never mid-frame.
        if (cur_last && (stop_req_q || i_stop)) begin
          state_d    = S_IDLE;
          stop_req_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      stop_req_q  <= 1'b0;
      underflow_q <= 1'b0;
      data_q      <= '0;
      h_q         <= '0;
      v_q         <= '0;
      new_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_req_q  <= stop_req_d;
      underflow_q <= underflow_d;
      data_q      <= data_d;
      h_q         <= h_d;
      v_q         <= v_d;
      new_q       <= new_d;
      done_q      <= done_d;
    end
  end

  assign pix.o_pix_req = pix_req;
  assign o_data        = data_q;
  assign o_h_cursor    = h_q;
  assign o_v_cursor    = v_q;
  assign o_is_new_read = new_q;
  assign o_frame_done  = done_q;
  assign o_underflow   = underflow_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed/randomized bench for pixel_stream_tx on a reduced raster,
// checked cycle by cycle against a frame-index reference model.
module tb_pixel_stream_tx;

  localparam int H  = 24;
  localparam int V  = 12;
  localparam int HA = 16;
  localparam int VA = 8;
  localparam int DW = 15;
  localparam int N  = H * V;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic          o_is_new_read, o_frame_done, o_underflow;
  logic [DW-1:0] o_data;
  logic [10:0]   o_h_cursor, o_v_cursor;

  pixel_stream_tx_if #(.DATA_SIZE(DW)) pix ();

  pixel_stream_tx #(
    .H_LIMIT(H), .V_LIMIT(V), .H_ACTIVE(HA), .V_ACTIVE(VA), .DATA_SIZE(DW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .pix          (pix),
    .o_is_new_read(o_is_new_read),
    .o_data       (o_data),
    .o_h_cursor   (o_h_cursor),
    .o_v_cursor   (o_v_cursor),
    .o_frame_done (o_frame_done),
    .o_underflow  (o_underflow)
  );

  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int req_cnt  = 0;

  // Reference model: streaming flag, sample index within the frame,
  // pending stop request and sticky underflow.
  bit            m_stream = 0;
  bit            m_stop_pend = 0;
  bit            m_uf = 0;
  int            m_k = 0;
  logic [DW-1:0] e_data = '0;
  int            e_h = 0, e_v = 0;
  bit            e_new = 0, e_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("o_data",        32'(o_data),        32'(e_data));
    chk("o_h_cursor",    32'(o_h_cursor),    32'(e_h));
    chk("o_v_cursor",    32'(o_v_cursor),    32'(e_v));
    chk("o_is_new_read", 32'(o_is_new_read), 32'(e_new));
    chk("o_frame_done",  32'(o_frame_done),  32'(e_done));
    chk("o_underflow",   32'(o_underflow),   32'(m_uf));
  endtask

  task automatic step(input bit st, input bit sp, input bit vl, input logic [DW-1:0] d);
    int  h, v;
    bit  act;
    i_start         = st;
    i_stop          = sp;
    pix.i_pix_valid = vl;
    pix.i_pix_data  = d;
    #1;
    e_data = '0; e_h = 0; e_v = 0; e_new = 0; e_done = 0;
    if (pix.o_pix_req === 1'b1) req_cnt++;
    if (!m_stream) begin
      chk("pix_req_idle", 32'(pix.o_pix_req), 32'd0);
      if (st) begin
        m_stream = 1; m_k = 0; m_uf = 0; m_stop_pend = sp;
      end
    end else begin
      h   = m_k % H;
      v   = m_k / H;
      act = (h < HA) && (v < VA);
      chk("pix_req", 32'(pix.o_pix_req), 32'(act && vl));
      if (act && vl)  e_data = d;
      if (act && !vl) m_uf = 1;
      e_h = h; e_v = v;
      e_new  = (m_k == 0);
      e_done = (m_k == N - 1);
      if (sp) m_stop_pend = 1;
      if (m_k == N - 1) begin
        m_k = 0;
        if (m_stop_pend) begin m_stream = 0; m_stop_pend = 0; end
      end else begin
        m_k++;
      end
    end
    @(negedge i_clk);
    chk_outputs();
  endtask

  task automatic async_reset();
    #2;
    i_rst_n = 1'b0;
    #1;
    m_stream = 0; m_stop_pend = 0; m_uf = 0; m_k = 0;
    e_data = '0; e_h = 0; e_v = 0; e_new = 0; e_done = 0;
    chk_outputs();
    chk("pix_req_rst", 32'(pix.o_pix_req), 32'd0);
    @(negedge i_clk);
    chk_outputs();
    i_rst_n = 1'b1;
  endtask

  initial begin
    pix.i_pix_valid = 1'b0;
    pix.i_pix_data  = '0;
    repeat (2) @(negedge i_clk);
    chk_outputs();
    chk("pix_req_por", 32'(pix.o_pix_req), 32'd0);
    i_rst_n = 1'b1;

    // Idle without start: nothing moves.
    repeat (3) step(0, 0, 1, DW'($urandom));

    // Frame A: valid always except a single drop at (10,3); data = sample index.
    step(1, 0, 1, '0);
    req_cnt = 0;
    for (int k = 0; k < N; k++)
      step(0, 0, !((k % H == 10) && (k / H == 3)), DW'(k));
    chk("req_count_A", 32'(req_cnt), 32'(HA * VA - 1));

    // Frame B follows gap-free; random valid, stop pulse plus a stray start mid-frame.
    for (int k = 0; k < N; k++)
      step((k == N / 2 + 7), (k == N / 2), ($urandom_range(3) != 0), DW'($urandom));

    // Back in idle: underflow holds until the next start.
    repeat (5) step(0, 0, 1, DW'($urandom));

    // Frame C: start and stop together -> exactly one frame.
    step(1, 1, 1, DW'($urandom));
    for (int k = 0; k < N; k++)
      step(0, 0, ($urandom_range(7) != 0), DW'($urandom));
    repeat (3) step(0, 0, 1, DW'($urandom));

    // Frame D: abandoned by an asynchronous reset mid-frame.
    step(1, 0, 1, DW'($urandom));
    for (int k = 0; k < (VA / 2) * H + 5; k++)
      step(0, 0, 1, DW'($urandom));
    async_reset();
    repeat (3) step(0, 0, 1, DW'($urandom));

    // Frame E: restart from origin with stop held, then idle.
    step(1, 1, 1, DW'($urandom));
    req_cnt = 0;
    for (int k = 0; k < N; k++)
      step(0, 1, 1, DW'($urandom));
    chk("req_count_E", 32'(req_cnt), 32'(HA * VA));
    repeat (3) step(0, 0, 1, DW'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
